// File: rtl/decim_pkg.sv
// Shared types and default constants for the decimation scheduler.
package decim_pkg;
  localparam int DEF_NUM_CH          = 4;
  localparam int DEF_DATA_BITS       = 17;
  localparam int DEF_DECIMATION_NUM  = 32;
  localparam int DEF_DECIMATION_BITS = 5;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef logic [DEF_DECIMATION_BITS-1:0] phase_t;
endpackage

// File: rtl/decim_sched_rr_arbiter.sv
// One-hot channel arbiter. DECIM_SCHED_RR_EN selects round-robin from a
// start pointer; otherwise the lowest requesting index wins.
module rr_arbiter #(
  parameter int NUM_CH  = 4
`ifdef DECIM_SCHED_RR_EN
  , parameter int CH_BITS = 2
`endif
) (
  input  logic [NUM_CH-1:0]  i_req,
  input  logic               i_en,
`ifdef DECIM_SCHED_RR_EN
  input  logic [CH_BITS-1:0] i_ptr,
`endif
  output logic [NUM_CH-1:0]  o_grant
);
`ifdef DECIM_SCHED_RR_EN
  logic [CH_BITS-1:0] w_idx;
  logic               w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = i_ptr + CH_BITS'(i);
      if (i_en && !w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end
`else
  always_comb begin
    o_grant = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_en && i_req[i]) begin
        o_grant    = '0;
        o_grant[i] = 1'b1;
      end
    end
  end
`endif
endmodule

// File: rtl/decim_sched.sv
// Multi-channel decimation scheduler: arbitrates channel samples into one
// decimated output stream. Arbitration mode set by DECIM_SCHED_RR_EN.
module decim_sched
  import decim_pkg::*;
#(
  parameter int NUM_CH          = DEF_NUM_CH,
  parameter int CH_BITS         = $clog2(NUM_CH),
  parameter int DATA_BITS       = DEF_DATA_BITS,
  parameter int DECIMATION_NUM  = DEF_DECIMATION_NUM,
  parameter int DECIMATION_BITS = $clog2(DECIMATION_NUM)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_enable,
  input  logic [DECIMATION_BITS-1:0]  i_cfg_ratio,
  input  logic [NUM_CH-1:0]           i_ch_valid,
  input  logic [NUM_CH*DATA_BITS-1:0] i_ch_data,
  output logic [NUM_CH-1:0]           o_ch_grant,
  output logic                        o_out_valid,
  output logic [CH_BITS-1:0]          o_out_ch,
  output logic [DATA_BITS-1:0]        o_out_data,
  input  logic                        i_out_ready,
  output logic                        o_busy
);
  state_t                                   r_state;
  logic [DECIMATION_BITS-1:0]               r_ratio;
  logic [NUM_CH-1:0][DECIMATION_BITS-1:0]   r_phase;
  logic                                     r_out_valid;
  logic [CH_BITS-1:0]                       r_out_ch;
  logic [DATA_BITS-1:0]                     r_out_data;

  logic [NUM_CH-1:0]    w_grant;
  logic                 w_en;
  logic                 w_any;
  logic                 w_emit;
  logic [CH_BITS-1:0]   w_gidx;
  logic [DATA_BITS-1:0] w_data;

  // Grant only while running, still enabled, and the output slot can take a sample.
  assign w_en = (r_state == RUN) && i_enable && (!r_out_valid || i_out_ready);

`ifdef DECIM_SCHED_RR_EN
  logic [CH_BITS-1:0] r_ptr;

  rr_arbiter #(.NUM_CH(NUM_CH), .CH_BITS(CH_BITS)) u_arb (
    .i_req(i_ch_valid), .i_en(w_en), .i_ptr(r_ptr), .o_grant(w_grant)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                               r_ptr <= '0;
    else if (r_state == IDLE && i_enable)     r_ptr <= '0;
    else if (w_any)
      r_ptr <= (w_gidx == CH_BITS'(NUM_CH - 1)) ? '0 : w_gidx + 1'b1;
  end
`else
  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .i_req(i_ch_valid), .i_en(w_en), .o_grant(w_grant)
  );
`endif

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (w_grant[i]) w_gidx = CH_BITS'(i);
  end

  assign w_any  = |w_grant;
  assign w_data = i_ch_data[w_gidx*DATA_BITS +: DATA_BITS];
  // Ratio 0 makes ratio-1 all ones, giving the full 2^DECIMATION_BITS wrap.
  assign w_emit = w_any && (r_phase[w_gidx] == r_ratio - 1'b1);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= IDLE;
      r_ratio     <= '0;
      r_phase     <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_data  <= '0;
    end else begin
      if (r_out_valid && i_out_ready) r_out_valid <= 1'b0;
      case (r_state)
        IDLE: if (i_enable) begin
          r_state <= RUN;
          r_ratio <= i_cfg_ratio;
          r_phase <= '0;
        end
        RUN: if (!i_enable) begin
          r_state <= DRAIN;
        end else if (w_any) begin
          if (w_emit) begin
            r_phase[w_gidx] <= '0;
            r_out_valid     <= 1'b1;
            r_out_ch        <= w_gidx;
            r_out_data      <= w_data;
          end else begin
            r_phase[w_gidx] <= r_phase[w_gidx] + 1'b1;
          end
        end
        DRAIN: if (!r_out_valid) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ch_grant  = w_grant;
  assign o_out_valid = r_out_valid;
  assign o_out_ch    = r_out_ch;
  assign o_out_data  = r_out_data;
  assign o_busy      = (r_state != IDLE);
endmodule

// File: tb/tb_decim_sched.sv
// Directed bench for decim_sched; expectations follow the arbitration mode
// selected by DECIM_SCHED_RR_EN.
module tb_decim_sched;
  localparam int NUM_CH = 4, CH_BITS = 2, DATA_BITS = 17, DBITS = 5;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        enable;
  logic [DBITS-1:0]            cfg_ratio;
  logic [NUM_CH-1:0]           ch_valid;
  logic [NUM_CH*DATA_BITS-1:0] ch_data;
  logic [NUM_CH-1:0]           ch_grant;
  logic                        out_valid;
  logic [CH_BITS-1:0]          out_ch;
  logic [DATA_BITS-1:0]        out_data;
  logic                        out_ready;
  logic                        busy;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  decim_sched dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_cfg_ratio(cfg_ratio),
    .i_ch_valid(ch_valid), .i_ch_data(ch_data), .o_ch_grant(ch_grant),
    .o_out_valid(out_valid), .o_out_ch(out_ch), .o_out_data(out_data),
    .i_out_ready(out_ready), .o_busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input int val);
    ch_data[ch*DATA_BITS +: DATA_BITS] = DATA_BITS'(val);
  endtask

  task automatic stop_run;
    enable = 1'b0; ch_valid = '0; out_ready = 1'b1;
    tick; tick;
    chk("stop_idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; cfg_ratio = '0; ch_valid = '0; ch_data = '0; out_ready = 1'b1;
    #3;
    chk("rst_grant", {28'd0, ch_grant}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ch", {30'd0, out_ch}, 32'd0);
    chk("rst_data", {15'd0, out_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    tick; rst = 1'b1;

    // Ratio 4, channel 0 only
    cfg_ratio = 5'd4; enable = 1'b1; tick;
    chk("r4_busy", {31'd0, busy}, 32'd1);
    ch_valid = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      set_data(0, 100 + k); #1;
      chk("r4_grant", {28'd0, ch_grant}, 32'd1);
      tick;
      chk("r4_valid", {31'd0, out_valid}, (k % 4 == 0) ? 32'd1 : 32'd0);
      if (k % 4 == 0) begin
        chk("r4_data", {15'd0, out_data}, 32'(100 + k));
        chk("r4_ch", {30'd0, out_ch}, 32'd0);
      end
    end
    stop_run;

    // Ratio 1, all channels valid
    cfg_ratio = 5'd1; enable = 1'b1; tick;
    ch_valid = 4'b1111;
    for (int i = 0; i < NUM_CH; i++) set_data(i, 'h1000 + i);
    for (int k = 0; k < 8; k++) begin
      int exp_ch;
`ifdef DECIM_SCHED_RR_EN
      exp_ch = k % NUM_CH;
`else
      exp_ch = 0;
`endif
      #1;
      chk("all_grant", {28'd0, ch_grant}, 32'(1 << exp_ch));
      tick;
      chk("all_valid", {31'd0, out_valid}, 32'd1);
      chk("all_ch", {30'd0, out_ch}, 32'(exp_ch));
      chk("all_data", {15'd0, out_data}, 32'('h1000 + exp_ch));
    end
    stop_run;

    // Backpressure, ratio 1
    cfg_ratio = 5'd1; enable = 1'b1; tick;
    ch_valid = 4'b0001; set_data(0, 'hAA1); tick;
    chk("bp_first", {15'd0, out_data}, 32'hAA1);
    out_ready = 1'b0; set_data(0, 'hAA2);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_nogrant", {28'd0, ch_grant}, 32'd0);
      tick;
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_data", {15'd0, out_data}, 32'hAA1);
    end
    out_ready = 1'b1; #1;
    chk("bp_release_grant", {28'd0, ch_grant}, 32'd1);
    tick;
    chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_next_data", {15'd0, out_data}, 32'hAA2);
    set_data(0, 'hAA3); tick;
    chk("bp_after_data", {15'd0, out_data}, 32'hAA3);
    stop_run;

    // Ratio 0 encodes 32, channel 1
    cfg_ratio = 5'd0; enable = 1'b1; tick;
    ch_valid = 4'b0010;
    for (int k = 1; k <= 64; k++) begin
      set_data(1, k); tick;
      chk("r0_valid", {31'd0, out_valid}, (k == 32 || k == 64) ? 32'd1 : 32'd0);
      if (k == 32 || k == 64) begin
        chk("r0_data", {15'd0, out_data}, 32'(k));
        chk("r0_ch", {30'd0, out_ch}, 32'd1);
      end
    end
    stop_run;

    // Drain with pending output; ch1 left mid-phase
    cfg_ratio = 5'd3; enable = 1'b1; tick;
    ch_valid = 4'b0010; set_data(1, 'h40); tick;
    ch_valid = 4'b0001;
    set_data(0, 'h51); tick;
    set_data(0, 'h52); tick;
    set_data(0, 'h53); tick;
    chk("dr_emit_valid", {31'd0, out_valid}, 32'd1);
    chk("dr_emit_data", {15'd0, out_data}, 32'h53);
    out_ready = 1'b0; enable = 1'b0; #1;
    chk("dr_fall_nogrant", {28'd0, ch_grant}, 32'd0);
    tick;
    chk("dr_busy", {31'd0, busy}, 32'd1);
    chk("dr_valid_held", {31'd0, out_valid}, 32'd1);
    chk("dr_data_held", {15'd0, out_data}, 32'h53);
    tick;
    chk("dr_busy2", {31'd0, busy}, 32'd1);
    chk("dr_nogrant", {28'd0, ch_grant}, 32'd0);
    out_ready = 1'b1; tick;
    chk("dr_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("dr_hs_busy", {31'd0, busy}, 32'd1);
    tick;
    chk("dr_idle_busy", {31'd0, busy}, 32'd0);
    cfg_ratio = 5'd2; enable = 1'b1; ch_valid = 4'b0010; set_data(1, 'h71); #1;
    chk("idle_nogrant", {28'd0, ch_grant}, 32'd0);
    tick; tick;
    chk("re_first_valid", {31'd0, out_valid}, 32'd0);
    set_data(1, 'h72); tick;
    chk("re_second_valid", {31'd0, out_valid}, 32'd1);
    chk("re_second_data", {15'd0, out_data}, 32'h72);
    chk("re_second_ch", {30'd0, out_ch}, 32'd1);
    stop_run;

    // Asynchronous reset with a pending output
    cfg_ratio = 5'd2; enable = 1'b1; out_ready = 1'b0; tick;
    ch_valid = 4'b0001; set_data(0, 'h81); tick;
    set_data(0, 'h82); tick;
    chk("ar_pend_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b0; #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_data", {15'd0, out_data}, 32'd0);
    chk("ar_ch", {30'd0, out_ch}, 32'd0);
    chk("ar_grant", {28'd0, ch_grant}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    tick;
    cfg_ratio = 5'd3; out_ready = 1'b1; rst = 1'b1;
    chk("ar_idle", {31'd0, busy}, 32'd0);
    tick;
    chk("ar_run", {31'd0, busy}, 32'd1);
    set_data(0, 'h91); tick;
    chk("ar_g1", {31'd0, out_valid}, 32'd0);
    set_data(0, 'h92); tick;
    chk("ar_g2", {31'd0, out_valid}, 32'd0);
    set_data(0, 'h93); tick;
    chk("ar_g3_valid", {31'd0, out_valid}, 32'd1);
    chk("ar_g3_data", {15'd0, out_data}, 32'h93);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
